// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg: shared CPU fetch types and constants
package pc_fetch_pkg;
  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;
  localparam logic [31:0] PC_INC = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/pc_fetch.sv
// pc_fetch: PC register and single-outstanding instruction fetch with one-entry hand-off
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);
  fetch_state_t state;
  logic [31:0] pc;
  logic [31:0] req_pc;
  logic squash;
  logic [31:0] target;
  assign target = word_align(redirect_pc);
  assign imem_addr = pc;
  assign imem_req_valid = (state == REQ) && !reset;
  assign inst_valid = (state == HOLD) && !redirect && !reset;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= REQ;
      pc <= RESET_PC;
      req_pc <= '0;
      squash <= 1'b0;
      inst <= '0;
      inst_pc <= '0;
    end else begin
      unique case (state)
        REQ: begin
          if (imem_req_ready) begin
            req_pc <= pc;
            pc <= redirect ? target : pc + PC_INC;
            squash <= redirect;
            state <= WAIT;
          end else if (redirect) begin
            pc <= target;
          end
        end
        WAIT: begin
          if (redirect) pc <= target;
          if (imem_rsp_valid) begin
            squash <= 1'b0;
            if (squash || redirect) begin
              state <= REQ;
            end else begin
              inst <= imem_rsp_data;
              inst_pc <= req_pc;
              state <= HOLD;
            end
          end else if (redirect) begin
            squash <= 1'b1;
          end
        end
        HOLD: begin
          if (redirect) begin
            pc <= target;
            state <= REQ;
          end else if (inst_ready) begin
            state <= REQ;
          end
        end
        default: state <= REQ;
      endcase
    end
  end
endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: directed scenarios plus randomized fetch traffic against a program-order model
module tb_pc_fetch;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic req_ready = 1'b0;
  logic rsp_valid = 1'b0;
  logic [31:0] rsp_data = '0;
  logic inst_ready = 1'b0;
  logic req_valid, inst_valid;
  logic [31:0] addr, inst, inst_pc;
  logic w_req_valid, w_inst_valid;
  logic [31:0] w_addr, w_inst, w_inst_pc;

  int errors = 0;
  int checks = 0;
  bit mem_busy = 0;
  int mem_wait = 0;
  logic [31:0] mem_addr = '0;
  int lat_min = 0;
  int lat_max = 0;
  bit spurious = 0;
  logic [31:0] exp_pc = '0;
  int xfers = 0;

  always #5 clk = ~clk;

  pc_fetch dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_addr(addr),
    .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc)
  );

  pc_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .reset(reset), .redirect(1'b0), .redirect_pc(32'h0),
    .imem_req_valid(w_req_valid), .imem_req_ready(1'b1), .imem_addr(w_addr),
    .imem_rsp_valid(1'b0), .imem_rsp_data(32'h0),
    .inst_valid(w_inst_valid), .inst_ready(1'b1), .inst(w_inst), .inst_pc(w_inst_pc)
  );

  task automatic drive_sample;
    if (mem_busy && mem_wait == 0) begin
      rsp_valid = 1'b1;
      rsp_data = 32'hA0 + mem_addr;
    end else if (spurious && !mem_busy && $urandom_range(0, 7) == 0) begin
      rsp_valid = 1'b1;
      rsp_data = $urandom;
    end else begin
      rsp_valid = 1'b0;
      rsp_data = $urandom;
    end
    #1;
  endtask

  task automatic advance;
    logic acc, xf;
    acc = req_valid && req_ready;
    xf = inst_valid && inst_ready;
    if (mem_busy && mem_wait == 0) mem_busy = 0;
    else if (mem_busy) mem_wait--;
    if (acc) begin
      mem_busy = 1;
      mem_addr = addr;
      mem_wait = int'($urandom_range(lat_min, lat_max));
    end
    if (reset) exp_pc = 32'h0;
    else if (redirect) exp_pc = {redirect_pc[31:2], 2'b00};
    else if (xf) begin
      exp_pc = exp_pc + 32'd4;
      xfers++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    redirect = 1'b0;
    req_ready = 1'b1;
    inst_ready = 1'b1;
    mem_busy = 0;
    lat_min = 0;
    lat_max = 0;
    drive_sample;
    advance;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    req_ready = 1'b1;
    inst_ready = 1'b1;
    drive_sample;
    checks++;
    if (req_valid !== 1'b0 || inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valids: req_valid=%b inst_valid=%b, expected 0 0", req_valid, inst_valid);
    end
    advance;
    reset = 1'b0;
    drive_sample;
    checks++;
    if (req_valid !== 1'b1 || addr !== 32'h0 || inst !== 32'h0 || inst_pc !== 32'h0 || inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: req_valid=%b addr=%h inst=%h inst_pc=%h inst_valid=%b, expected 1 0 0 0 0",
               req_valid, addr, inst, inst_pc, inst_valid);
    end
    advance;
  endtask

  task automatic test_sequential;
    logic [31:0] e;
    for (int k = 1; k < 9; k++) begin
      drive_sample;
      e = 32'(4 * (k / 3));
      if (k % 3 == 0) begin
        checks++;
        if (req_valid !== 1'b1 || addr !== e) begin
          errors++;
          $display("FAIL seq_addr: req_valid=%b addr=%h, expected 1 %h", req_valid, addr, e);
        end
      end
      if (k % 3 == 2) begin
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== e || inst !== 32'hA0 + e) begin
          errors++;
          $display("FAIL seq_inst: inst_valid=%b inst_pc=%h inst=%h, expected 1 %h %h",
                   inst_valid, inst_pc, inst, e, 32'hA0 + e);
        end
      end
      advance;
    end
  endtask

  task automatic test_stall;
    do_reset;
    for (int k = 0; k < 5; k++) begin
      drive_sample;
      advance;
    end
    inst_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive_sample;
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'h4 || inst !== 32'hA4 || req_valid !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold: inst_valid=%b inst_pc=%h inst=%h req_valid=%b, expected 1 4 a4 0",
                 inst_valid, inst_pc, inst, req_valid);
      end
      advance;
    end
    inst_ready = 1'b1;
    drive_sample;
    advance;
    drive_sample;
    checks++;
    if (req_valid !== 1'b1 || addr !== 32'h8) begin
      errors++;
      $display("FAIL stall_resume: req_valid=%b addr=%h, expected 1 8", req_valid, addr);
    end
    advance;
  endtask

  task automatic test_redirect_wait;
    redirect = 1'b1;
    redirect_pc = 32'h40;
    drive_sample;
    checks++;
    if (inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL redir_wait_valid: inst_valid=%b, expected 0", inst_valid);
    end
    advance;
    redirect = 1'b0;
    drive_sample;
    checks++;
    if (req_valid !== 1'b1 || addr !== 32'h40) begin
      errors++;
      $display("FAIL redir_wait_addr: req_valid=%b addr=%h, expected 1 40", req_valid, addr);
    end
    advance;
    drive_sample;
    advance;
    drive_sample;
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h40 || inst !== 32'hE0) begin
      errors++;
      $display("FAIL redir_wait_inst: inst_valid=%b inst_pc=%h inst=%h, expected 1 40 e0", inst_valid, inst_pc, inst);
    end
  endtask

  task automatic test_redirect_hold;
    redirect = 1'b1;
    redirect_pc = 32'h103;
    inst_ready = 1'b1;
    drive_sample;
    checks++;
    if (inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL redir_hold_valid: inst_valid=%b, expected 0", inst_valid);
    end
    advance;
    redirect = 1'b0;
    drive_sample;
    checks++;
    if (req_valid !== 1'b1 || addr !== 32'h100) begin
      errors++;
      $display("FAIL redir_hold_addr: req_valid=%b addr=%h, expected 1 100", req_valid, addr);
    end
    advance;
  endtask

  task automatic test_reset_mid;
    bit found;
    found = 0;
    lat_min = 3;
    lat_max = 3;
    for (int k = 0; k < 10 && !found; k++) begin
      drive_sample;
      found = req_valid && req_ready;
      advance;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reset_mid_accept: no request accepted within 10 cycles, expected one");
    end
    reset = 1'b1;
    drive_sample;
    checks++;
    if (req_valid !== 1'b0 || inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_gate: req_valid=%b inst_valid=%b, expected 0 0", req_valid, inst_valid);
    end
    advance;
    reset = 1'b0;
    req_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive_sample;
      checks++;
      if (addr !== 32'h0 || inst_valid !== 1'b0 || req_valid !== 1'b1) begin
        errors++;
        $display("FAIL reset_mid_late: addr=%h inst_valid=%b req_valid=%b, expected 0 0 1", addr, inst_valid, req_valid);
      end
      advance;
    end
    lat_min = 0;
    lat_max = 0;
    req_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      drive_sample;
      advance;
    end
    drive_sample;
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst !== 32'hA0) begin
      errors++;
      $display("FAIL reset_mid_refetch: inst_valid=%b inst_pc=%h inst=%h, expected 1 0 a0", inst_valid, inst_pc, inst);
    end
    advance;
  endtask

  task automatic test_wrap;
    do_reset;
    drive_sample;
    checks++;
    if (w_req_valid !== 1'b1 || w_addr !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_first: req_valid=%b addr=%h, expected 1 fffffffc", w_req_valid, w_addr);
    end
    advance;
    drive_sample;
    checks++;
    if (w_addr !== 32'h0 || w_req_valid !== 1'b0 || w_inst_valid !== 1'b0 || w_inst !== 32'h0 || w_inst_pc !== 32'h0) begin
      errors++;
      $display("FAIL wrap_next: addr=%h req_valid=%b inst_valid=%b inst=%h inst_pc=%h, expected 0 0 0 0 0",
               w_addr, w_req_valid, w_inst_valid, w_inst, w_inst_pc);
    end
    advance;
  endtask

  task automatic test_random;
    bit prev_hold;
    logic [31:0] p_inst, p_pc;
    do_reset;
    lat_min = 0;
    lat_max = 3;
    spurious = 1;
    xfers = 0;
    prev_hold = 0;
    p_inst = '0;
    p_pc = '0;
    for (int c = 0; c < 3000; c++) begin
      redirect = ($urandom_range(0, 15) == 0);
      redirect_pc = $urandom;
      req_ready = ($urandom_range(0, 3) != 0);
      inst_ready = ($urandom_range(0, 2) != 0);
      drive_sample;
      if (req_valid === 1'b1) begin
        checks++;
        if (mem_busy) begin
          errors++;
          $display("FAIL rnd_outstanding: cycle %0d req_valid=1 with a request outstanding, expected 0", c);
        end
      end
      if (req_valid && req_ready) begin
        checks++;
        if (addr !== exp_pc) begin
          errors++;
          $display("FAIL rnd_req_addr: cycle %0d addr=%h, expected %h", c, addr, exp_pc);
        end
      end
      if (inst_valid && inst_ready) begin
        checks++;
        if (inst_pc !== exp_pc || inst !== 32'hA0 + exp_pc) begin
          errors++;
          $display("FAIL rnd_xfer: cycle %0d inst_pc=%h inst=%h, expected %h %h", c, inst_pc, inst, exp_pc, 32'hA0 + exp_pc);
        end
      end
      if (redirect) begin
        checks++;
        if (inst_valid !== 1'b0) begin
          errors++;
          $display("FAIL rnd_redir_valid: cycle %0d inst_valid=%b, expected 0", c, inst_valid);
        end
      end
      if (prev_hold && !redirect) begin
        checks++;
        if (inst_valid !== 1'b1 || inst !== p_inst || inst_pc !== p_pc) begin
          errors++;
          $display("FAIL rnd_stall: cycle %0d inst_valid=%b inst=%h inst_pc=%h, expected 1 %h %h",
                   c, inst_valid, inst, inst_pc, p_inst, p_pc);
        end
      end
      prev_hold = inst_valid && !inst_ready;
      p_inst = inst;
      p_pc = inst_pc;
      advance;
    end
    spurious = 0;
    redirect = 1'b0;
    checks++;
    if (xfers < 100) begin
      errors++;
      $display("FAIL rnd_progress: transfers=%0d, expected at least 100", xfers);
    end
  endtask

  initial begin
    test_reset;
    test_sequential;
    test_stall;
    test_redirect_wait;
    test_redirect_hold;
    test_reset_mid;
    test_wrap;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/pc_fetch.md
# pc_fetch

Program-counter register and instruction-fetch sequencer for the single-issue CPU. It holds the architectural PC, issues one instruction-memory read at a time, and buffers the returned word in a one-entry hand-off register for decode. It accepts the PC redirect produced by the `pc_branch` next-PC logic and squashes wrong-path fetches.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `redirect` input 1: taken branch/jump; load `redirect_pc`.
- `redirect_pc` input 32: target from `pc_branch` `pc_out`; bits [1:0] are ignored and forced to 0.
- `imem_req_valid` output 1: read request.
- `imem_req_ready` input 1: memory accepts the request this cycle.
- `imem_addr` output 32: word address of the request, equal to the current PC.
- `imem_rsp_valid` input 1: read data returned.
- `imem_rsp_data` input 32: instruction word.
- `inst_valid` output 1: hand-off register holds a valid instruction.
- `inst_ready` input 1: decode consumes the instruction.
- `inst` output 32: buffered instruction.
- `inst_pc` output 32: PC of `inst`.

## Operation
- Registers: `pc`, `req_pc`, `inst`, `inst_pc`, `squash`, and state ∈ {REQ, WAIT, HOLD}.
- Reset:
  - state=REQ, `pc`=RESET_PC, `squash`=0, `inst`=0, `inst_pc`=0.
  - `imem_req_valid` and `inst_valid` are 0 while `reset` is high.
  - `imem_addr` = `pc`.
- `imem_req_valid` = (state==REQ) & !reset.
- `inst_valid` = (state==HOLD) & !redirect & !reset.
- REQ:
  - On `imem_req_ready`: `req_pc`←`pc`, `pc`←`pc`+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0), go to WAIT.
  - If `redirect` arrives without `imem_req_ready`: `pc`←`redirect_pc`, stay in REQ. `imem_addr` may change while valid; imem requires no address stability.
  - If `redirect` and `imem_req_ready` arrive together: the request is accepted, `squash`←1, `pc`←`redirect_pc`, go to WAIT.
- WAIT:
  - On `imem_rsp_valid` with `squash`=0: `inst`←data, `inst_pc`←`req_pc`, go to HOLD.
  - On `imem_rsp_valid` with `squash`=1: drop the data, `squash`←0, go to REQ.
  - `redirect` in WAIT: `pc`←`redirect_pc`, `squash`←1. If `imem_rsp_valid` is high in the same cycle, the data is dropped, `squash`←0, and the block goes to REQ.
- HOLD:
  - On `inst_valid` & `inst_ready`: go to REQ.
  - On `redirect`: no transfer occurs (`inst_valid` is forced low), `pc`←`redirect_pc`, go to REQ.
- `imem_rsp_valid` outside WAIT is ignored.
- At most one request is outstanding at any time.
- `reset` mid-operation: all state returns to reset values next cycle. A response arriving after reset for a pre-reset request lands in REQ and is ignored.

## Timing
- Minimum loop is 3 cycles per instruction (REQ accept → WAIT with response → HOLD transfer), assuming a 1-cycle memory.
- `inst_valid` rises the cycle after `imem_rsp_valid` is sampled in WAIT.
- A redirect takes effect on `imem_addr` the cycle after it is asserted.
- Stalls:
  - `imem_req_ready` low holds REQ indefinitely.
  - `inst_ready` low holds HOLD indefinitely, with `inst` and `inst_pc` stable.

## Structure
- Shared CPU package holds:
  - state encoding `fetch_state_t` (REQ=2'd0, WAIT=2'd1, HOLD=2'd2)
  - `PC_INC`=32'd4
  - `RESET_PC_DEFAULT`
- Single module. Next-PC/branch arithmetic stays in the external `pc_branch`; `pc_fetch` only adds 4.

## Test plan
- Reset, `imem_req_ready`=1, 1-cycle memory returning 32'hA0+addr → `imem_addr` sequence 0, 4, 8 every 3 cycles; `inst_pc` = 0, 4, 8; `inst` = 32'hA0, A4, A8.
- `inst_ready`=0 for 5 cycles in HOLD at `inst_pc`=4 → `inst` and `inst_pc` stable; no new request issued; fetch resumes at 8.
- `redirect`=1, `redirect_pc`=32'h40 during WAIT for address 8 → response for 8 is dropped, next `imem_addr`=32'h40, next `inst_pc`=32'h40.
- `redirect` in HOLD with `inst_ready`=1, `redirect_pc`=32'h103 → `inst_valid` low that cycle, next `imem_addr`=32'h100.
- RESET_PC=32'hFFFF_FFFC → `imem_addr` sequence FFFF_FFFC then 0.
- `reset` asserted during WAIT with a late response → `imem_addr`=RESET_PC, no spurious `inst_valid`.
